// File: rtl/mfcc_frame_capture.sv
// MFCC per-frame coefficient capture buffer with random-access readback.
// Define MFCC_CAPTURE_PINGPONG_EN for a two-bank buffer (capture/read split).
module mfcc_frame_capture #(
    parameter int COEF_N  = 13,
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 8,
    parameter int SRC_LAT = 1,
    parameter int FRAME_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               drop_err,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               src_en,
    output logic [ADDR_W-1:0]  src_addr,
    input  logic [DATA_W-1:0]  src_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid
);

    localparam int IW = (COEF_N > 1) ? $clog2(COEF_N) : 1;
`ifdef MFCC_CAPTURE_PINGPONG_EN
    localparam int MW = IW + 1;
`else
    localparam int MW = IW;
`endif
    localparam int MDEPTH = 1 << MW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        drain_q;
    logic              last_issue;
    logic              drain_end;
    logic              launch;

    logic              en_sr   [SRC_LAT];
    logic [IW-1:0]     addr_sr [SRC_LAT];
    logic              en_d;
    logic [IW-1:0]     addr_d;

    logic [DATA_W-1:0] mem [MDEPTH];
    logic [MW-1:0]     wr_idx;
    logic [MW-1:0]     rd_idx;

    assign last_issue = (state == S_FETCH) &&
                        (addr_q == ADDR_W'(COEF_N - 1));
    assign drain_end  = (state == S_DRAIN) &&
                        (drain_q == 3'(SRC_LAT - 1));
    assign launch     = start &&
                        ((state == S_IDLE) || (state == S_DONE));

    assign busy     = (state == S_FETCH) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign src_en   = (state == S_FETCH);
    assign src_addr = addr_q;

    assign en_d   = en_sr[SRC_LAT-1];
    assign addr_d = addr_sr[SRC_LAT-1];

`ifdef MFCC_CAPTURE_PINGPONG_EN
    logic rd_bank;
    assign wr_idx = {~rd_bank, addr_d};
    assign rd_idx = {rd_bank, rd_addr[IW-1:0]};

    // Read bank flips once the capture bank holds a complete frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank <= 1'b0;
        end else if (drain_end) begin
            rd_bank <= ~rd_bank;
        end
    end
`else
    assign wr_idx = addr_d;
    assign rd_idx = rd_addr[IW-1:0];
`endif

    // Next-state logic for the capture sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_FETCH : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, issue address and drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= (state == S_FETCH && !last_issue) ?
                       addr_q + 1'b1 : '0;
            drain_q <= (state == S_DRAIN) ? drain_q + 1'b1 : '0;
        end
    end

    // Align enable/index with the source read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SRC_LAT; i++) begin
                en_sr[i]   <= 1'b0;
                addr_sr[i] <= '0;
            end
        end else begin
            en_sr[0]   <= src_en;
            addr_sr[0] <= addr_q[IW-1:0];
            for (int i = 1; i < SRC_LAT; i++) begin
                en_sr[i]   <= en_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    // Status: rejected-start pulse, frame count, readable flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err  <= 1'b0;
            frame_cnt <= '0;
            rd_valid  <= 1'b0;
        end else begin
            drop_err <= start && busy;
            if (drain_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (drain_end) begin
                rd_valid <= 1'b1;
`ifndef MFCC_CAPTURE_PINGPONG_EN
            end else if (launch) begin
                rd_valid <= 1'b0;
`endif
            end
        end
    end

    // Coefficient store; contents survive reset
    always_ff @(posedge clk) begin
        if (en_d) begin
            mem[wr_idx] <= src_data;
        end
    end

    // Registered readback, out-of-frame indices read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr < ADDR_W'(COEF_N)) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
